// File: rtl/simplebus_mem_slave.sv
// SimpleBus memory slave: 64-bit word store with fixed response latency,
// critical-word-first read bursts and write bursts closed by writeLast.
module simplebus_mem_slave #(
  parameter int ADDR_WORDS_LOG2 = 8,
  parameter int LATENCY         = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        req_ready,
  input  logic        req_valid,
  input  logic [31:0] req_bits_addr,
  input  logic [2:0]  req_bits_size,
  input  logic [3:0]  req_bits_cmd,
  input  logic [7:0]  req_bits_wmask,
  input  logic [63:0] req_bits_wdata,
  input  logic [15:0] req_bits_user,
  input  logic        resp_ready,
  output logic        resp_valid,
  output logic [3:0]  resp_bits_cmd,
  output logic [63:0] resp_bits_rdata,
  output logic [15:0] resp_bits_user
);

  // state     | meaning
  // ST_IDLE   | ready for a new request
  // ST_WAIT   | latency countdown before the first response beat
  // ST_RBEAT  | presenting read beats (single or 8-beat burst)
  // ST_WBURST | accepting writeBurst beats until writeLast
  // ST_WRESP  | presenting the single write response

  localparam int AW = ADDR_WORDS_LOG2;
  localparam logic [3:0] LAT_LOAD   = 4'(LATENCY - 1);
  localparam logic [3:0] CMD_WRITE  = 4'b0001;
  localparam logic [3:0] CMD_RBURST = 4'b0010;
  localparam logic [3:0] CMD_WBURST = 4'b0011;
  localparam logic [3:0] CMD_WLAST  = 4'b0111;
  localparam logic [3:0] RSP_READ   = 4'b0000;
  localparam logic [3:0] RSP_RLAST  = 4'b0110;
  localparam logic [3:0] RSP_WRESP  = 4'b0101;

  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_RBEAT, ST_WBURST, ST_WRESP} state_t;

  state_t          state;
  logic [63:0]     mem [0:(1<<AW)-1];
  logic [AW-1:0]   word_q;
  logic            burst_q;
  logic            write_q;
  logic [3:0]      lat_cnt;
  logic [2:0]      beat_cnt;

  logic [AW-1:0]   req_idx;
  logic            req_fire;
  logic            is_wr_cmd;
  logic            mem_we;
  logic [2:0]      nxt_off;
  logic [AW-1:0]   nxt_idx;
  logic            unused_bits;

  assign req_idx   = req_bits_addr[AW+2:3];
  assign req_fire  = req_valid && req_ready;
  assign is_wr_cmd = (req_bits_cmd == CMD_WRITE) || (req_bits_cmd == CMD_WBURST) ||
                     (req_bits_cmd == CMD_WLAST);
  // Every beat accepted in WBURST is a write, whatever its cmd.
  assign mem_we    = req_fire && !rst && ((state == ST_WBURST) || is_wr_cmd);
  assign nxt_off   = word_q[2:0] + beat_cnt + 3'd1;
  assign nxt_idx   = {word_q[AW-1:3], nxt_off};
  assign unused_bits = ^{req_bits_size, req_bits_addr[31:AW+3], req_bits_addr[2:0]};

  // Backing store is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 8; b++) begin
        if (req_bits_wmask[b]) mem[req_idx][8*b +: 8] <= req_bits_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      req_ready       <= 1'b1;
      resp_valid      <= 1'b0;
      resp_bits_cmd   <= 4'd0;
      resp_bits_rdata <= 64'd0;
      resp_bits_user  <= 16'd0;
      lat_cnt         <= 4'd0;
      beat_cnt        <= 3'd0;
      word_q          <= '0;
      burst_q         <= 1'b0;
      write_q         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_fire) begin
            word_q   <= req_idx;
            lat_cnt  <= LAT_LOAD;
            beat_cnt <= 3'd0;
            if (req_bits_cmd == CMD_WBURST) begin
              state <= ST_WBURST;
            end else begin
              resp_bits_user <= req_bits_user;
              write_q        <= is_wr_cmd;
              burst_q        <= (req_bits_cmd == CMD_RBURST);
              req_ready      <= 1'b0;
              state          <= ST_WAIT;
            end
          end
        end
        ST_WBURST: begin
          if (req_fire && req_bits_cmd != CMD_WBURST) begin
            resp_bits_user <= req_bits_user;
            write_q        <= 1'b1;
            burst_q        <= 1'b0;
            lat_cnt        <= LAT_LOAD;
            req_ready      <= 1'b0;
            state          <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (lat_cnt == 4'd0) begin
            resp_valid <= 1'b1;
            if (write_q) begin
              resp_bits_cmd   <= RSP_WRESP;
              resp_bits_rdata <= 64'd0;
              state           <= ST_WRESP;
            end else begin
              resp_bits_cmd   <= burst_q ? RSP_READ : RSP_RLAST;
              resp_bits_rdata <= mem[word_q];
              state           <= ST_RBEAT;
            end
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        ST_RBEAT: begin
          if (resp_ready) begin
            if (!burst_q || beat_cnt == 3'd7) begin
              resp_valid <= 1'b0;
              req_ready  <= 1'b1;
              state      <= ST_IDLE;
            end else begin
              beat_cnt        <= beat_cnt + 3'd1;
              resp_bits_rdata <= mem[nxt_idx];
              resp_bits_cmd   <= (beat_cnt == 3'd6) ? RSP_RLAST : RSP_READ;
            end
          end
        end
        ST_WRESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
